// File: rtl/pointcloud_pkg.sv
// Shared types and default sizes for the pointcloud match-scan path.
package pointcloud_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_IDXW  = 8;

   // Scanner control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/stream_match_scanner_if.sv
// Stream word bus between a producer and the match scanner.
//
// Handshake: a word transfers on a rising clock edge when In_valid and
// In_ready are both 1. The producer holds In_valid/In_data stable until that
// edge; In_ready never depends on In_valid, so there is no combinational loop.
interface stream_match_scanner_if #(
   parameter int WIDTH = pointcloud_pkg::DEF_WIDTH
);
   logic             In_valid;
   logic [WIDTH-1:0] In_data;
   logic             In_ready;

   modport master (output In_valid, output In_data, input In_ready);
   modport slave  (input In_valid, input In_data, output In_ready);
endinterface

// File: rtl/Comp.sv
// Equality comparator: z is 1 when both operands are identical.
module Comp
   import pointcloud_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             z
);

   assign z = (a == b);

endmodule

// File: rtl/stream_match_scanner.sv
// Latches a key and a length, scans that many stream words, and reports the
// first matching index, the match count and a one-cycle completion pulse.
module stream_match_scanner
   import pointcloud_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDXW  = DEF_IDXW
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Start,
   input  logic [WIDTH-1:0]       Key,
   input  logic [IDXW-1:0]        Len,
   stream_match_scanner_if.slave  in_bus,
   output logic                   Busy,
   output logic                   Done,
   output logic                   Found,
   output logic [IDXW-1:0]        Match_idx,
   output logic [IDXW:0]          Match_cnt,
   output state_t                 State
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] key_q;
   logic [IDXW-1:0]  len_q;
   logic [IDXW-1:0]  idx_q;
   logic             found_q;
   logic [IDXW-1:0]  match_idx_q;
   logic [IDXW:0]    match_cnt_q;
   logic             in_ready_w;
   logic             done_w;
   logic             is_match;
   logic             beat;
   logic             last_beat;

   // Equality of the current stream word against the latched key.
   Comp #(.WIDTH(WIDTH)) u_comp (
      .a (in_bus.In_data),
      .b (key_q),
      .z (is_match)
   );

   assign beat      = in_bus.In_valid && in_ready_w;
   assign last_beat = (idx_q == len_q - IDXW'(1));

   // State register.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and state-decoded outputs; a zero length skips SCAN entirely.
   always_comb begin
      state_nxt  = state;
      in_ready_w = 1'b0;
      done_w     = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start) begin
               state_nxt = (Len == '0) ? FIN : SCAN;
            end
         end
         SCAN: begin
            in_ready_w = 1'b1;
            if (beat && last_beat) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            done_w    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Key/length capture on Start and per-beat result accumulation.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         key_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         found_q     <= 1'b0;
         match_idx_q <= '0;
         match_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  key_q       <= Key;
                  len_q       <= Len;
                  idx_q       <= '0;
                  found_q     <= 1'b0;
                  match_idx_q <= '0;
                  match_cnt_q <= '0;
               end
            end
            SCAN: begin
               if (beat) begin
                  idx_q <= idx_q + IDXW'(1);
                  if (is_match) begin
                     match_cnt_q <= match_cnt_q + (IDXW + 1)'(1);
                     if (!found_q) begin
                        found_q     <= 1'b1;
                        match_idx_q <= idx_q;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_bus.In_ready = in_ready_w;
   assign Busy            = in_ready_w;
   assign Done            = done_w;
   assign Found           = found_q;
   assign Match_idx       = match_idx_q;
   assign Match_cnt       = match_cnt_q;
   assign State           = state;

endmodule

// File: tb/tb_stream_match_scanner.sv
// Bench for stream_match_scanner: directed scans plus randomized scans,
// results checked by a Done-triggered monitor against a reference model.
module tb_stream_match_scanner;
   import pointcloud_pkg::*;

   localparam int WIDTH = 8;
   localparam int IDXW  = 8;

   logic             Clk;
   logic             Rst_n;
   logic             Start;
   logic [WIDTH-1:0] Key;
   logic [IDXW-1:0]  Len;
   logic             Busy;
   logic             Done;
   logic             Found;
   logic [IDXW-1:0]  Match_idx;
   logic [IDXW:0]    Match_cnt;
   state_t           State;

   stream_match_scanner_if #(.WIDTH(WIDTH)) bus ();

   stream_match_scanner #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Start     (Start),
      .Key       (Key),
      .Len       (Len),
      .in_bus    (bus),
      .Busy      (Busy),
      .Done      (Done),
      .Found     (Found),
      .Match_idx (Match_idx),
      .Match_cnt (Match_cnt),
      .State     (State)
   );

   // ---------------- clock / reset / cycle counter ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   // {found, match_idx, match_cnt}
   logic [17:0] exp_q[$];
   int          exp_beats_q[$];
   int          exp_lat_q[$];   // -1: latency not checked
   int          start_cyc = 0;
   int          beats = 0;
   logic [7:0]  data_buf[256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: first index, count and presence of key among the first len words.
   function automatic logic [17:0] model(input logic [7:0] key, input int len);
      logic       f = 1'b0;
      logic [7:0] fi = '0;
      int         cnt = 0;
      for (int i = 0; i < len; i++) begin
         if (data_buf[i] == key) begin
            if (!f) fi = 8'(i);
            f = 1'b1;
            cnt++;
         end
      end
      return {f, fi, 9'(cnt)};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      if (!Rst_n) begin
         beats = 0;
      end else begin
         if (bus.In_valid && bus.In_ready) beats++;
         if (Done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(Done), 32'd0);
            end else begin
               logic [17:0] e;
               int          eb;
               int          el;
               e  = exp_q.pop_front();
               eb = exp_beats_q.pop_front();
               el = exp_lat_q.pop_front();
               check("found", 32'(Found), 32'(e[17]));
               check("match_idx", 32'(Match_idx), 32'(e[16:9]));
               check("match_cnt", 32'(Match_cnt), 32'(e[8:0]));
               check("handshakes", 32'(beats), 32'(eb));
               if (el >= 0) check("done_latency", 32'(cyc - start_cyc), 32'(el));
            end
            beats = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Run one scan over data_buf[0..len-1]; stalls of smin..smax idle cycles
   // precede every beat after the first; poke fires Start with another key mid-scan.
   task automatic run_scan(input logic [7:0] key, input int len,
                           input int smin, input int smax, input bit poke);
      exp_q.push_back(model(key, len));
      exp_beats_q.push_back(len);
      exp_lat_q.push_back((smax == 0) ? len : -1);
      Start = 1'b1;
      Key   = key;
      Len   = 8'(len);
      tick();
      start_cyc = cyc;
      Start = 1'b0;
      for (int i = 0; i < len; i++) begin
         bit hs;
         int guard;
         if (i > 0) begin
            int n;
            n = $urandom_range(smin, smax);
            bus.In_valid = 1'b0;
            repeat (n) tick();
         end
         bus.In_valid = 1'b1;
         bus.In_data  = data_buf[i];
         if (poke && i == 1) begin
            Start = 1'b1;
            Key   = 8'h01;
            Len   = 8'(len + 3);
         end
         guard = 0;
         hs    = 1'b0;
         while (!hs && guard < 50) begin
            hs = bus.In_ready;
            tick();
            guard++;
         end
         Start = 1'b0;
         if (!hs) begin
            check("beat_timeout", 32'(hs), 32'd1);
            i = len;
         end
      end
      bus.In_valid = 1'b0;
      begin
         int guard;
         guard = 0;
         while (!Done && guard < 10) begin
            tick();
            guard++;
         end
         if (!Done) check("done_timeout", 32'(Done), 32'd1);
      end
      tick();
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 32'(Busy), 32'd0);
      check({tag, "_done"}, 32'(Done), 32'd0);
      check({tag, "_found"}, 32'(Found), 32'd0);
      check({tag, "_idx"}, 32'(Match_idx), 32'd0);
      check({tag, "_cnt"}, 32'(Match_cnt), 32'd0);
      check({tag, "_ready"}, 32'(bus.In_ready), 32'd0);
      check({tag, "_state"}, 32'(State), 32'(IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Rst_n        = 1'b0;
      Start        = 1'b0;
      Key          = '0;
      Len          = '0;
      bus.In_valid = 1'b0;
      bus.In_data  = '0;

      // Reset held 3 cycles, then idle with Start low.
      repeat (3) tick();
      check_idle_zero("reset");
      Rst_n = 1'b1;
      repeat (3) tick();
      check_idle_zero("idle");

      // Single match.
      data_buf[0] = 8'h10; data_buf[1] = 8'hAA; data_buf[2] = 8'hF0; data_buf[3] = 8'h80;
      run_scan(8'hAA, 4, 0, 0, 1'b0);

      // Multiple matches with 2-cycle stalls.
      data_buf[0] = 8'hEA; data_buf[1] = 8'h00; data_buf[2] = 8'hEA;
      data_buf[3] = 8'hEA; data_buf[4] = 8'h11;
      run_scan(8'hEA, 5, 2, 2, 1'b0);

      // No match, then zero length.
      data_buf[0] = 8'h00; data_buf[1] = 8'h01; data_buf[2] = 8'h02;
      run_scan(8'h55, 3, 0, 0, 1'b0);
      run_scan(8'h55, 0, 0, 0, 1'b0);

      // Start with a different key mid-scan is ignored; next Start accepted.
      data_buf[0] = 8'h01; data_buf[1] = 8'h3C; data_buf[2] = 8'h01;
      data_buf[3] = 8'h3C; data_buf[4] = 8'h01;
      run_scan(8'h3C, 5, 0, 1, 1'b1);
      run_scan(8'h01, 5, 0, 0, 1'b0);

      // Reset mid-scan after 2 of 4 beats.
      data_buf[0] = 8'h3C; data_buf[1] = 8'h3C; data_buf[2] = 8'h00; data_buf[3] = 8'h3C;
      Start = 1'b1; Key = 8'h3C; Len = 8'd4;
      tick();
      Start = 1'b0;
      bus.In_valid = 1'b1; bus.In_data = data_buf[0];
      tick();
      bus.In_data = data_buf[1];
      tick();
      bus.In_valid = 1'b0;
      check("pre_reset_found", 32'(Found), 32'd1);
      Rst_n = 1'b0;
      tick();
      check_idle_zero("midreset");
      Rst_n = 1'b1;
      tick();
      run_scan(8'h3C, 4, 0, 0, 1'b0);

      // Randomized scans.
      for (int s = 0; s < 25; s++) begin
         logic [7:0] k;
         int         len;
         k   = 8'($urandom);
         len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) begin
            data_buf[i] = ($urandom_range(0, 2) == 0) ? k : 8'($urandom);
         end
         run_scan(k, len, 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
